// File: rtl/fpu_fmul_pipe.sv
// Pipelined floating-point multiplier: classify -> multiply -> normalise -> round/pack.
// A single global stall (in_ready) freezes every stage together.
module fpu_fmul_pipe #(
  parameter int EXP_W    = 11,
  parameter int FRAC_W   = 52,
  parameter int ROUND_EN = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+FRAC_W:0] srca,
  input  logic [EXP_W+FRAC_W:0] srcb,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+FRAC_W:0] dst,
  output logic [3:0]            flags
);

  localparam int W    = 1 + EXP_W + FRAC_W;
  localparam int MW   = FRAC_W + 1;
  localparam int PW   = 2 * FRAC_W + 2;
  localparam int EW   = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic [W-1:0]  QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

  // operand classification
  logic [W-1:0]       op      [2];
  logic               op_sign [2];
  logic [EXP_W-1:0]   op_exp  [2];
  logic [FRAC_W-1:0]  op_frac [2];
  logic               op_zero [2];
  logic               op_inf  [2];
  logic               op_nan  [2];

  assign op[0] = srca;
  assign op[1] = srcb;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_class
      assign op_sign[gi] = op[gi][W-1];
      assign op_exp[gi]  = op[gi][W-2:FRAC_W];
      assign op_frac[gi] = op[gi][FRAC_W-1:0];
      assign op_zero[gi] = (op_exp[gi] == '0);
      assign op_inf[gi]  = (&op_exp[gi]) && (op_frac[gi] == '0);
      assign op_nan[gi]  = (&op_exp[gi]) && (op_frac[gi] != '0);
    end
  endgenerate

  // stage 1 registers
  logic              s1_valid_q, s1_sign_q, s1_spec_q;
  logic [W-1:0]      s1_spec_val_q;
  logic [3:0]        s1_spec_flg_q;
  logic [EW-1:0]     s1_exp_q;
  logic [MW-1:0]     s1_ma_q, s1_mb_q;
  logic              s1_sign_d, s1_spec_d;
  logic [W-1:0]      s1_spec_val_d;
  logic [3:0]        s1_spec_flg_d;
  logic [EW-1:0]     s1_exp_d;
  logic              inf_times_zero;

  // stage 2 registers
  logic              s2_valid_q, s2_sign_q, s2_spec_q;
  logic [W-1:0]      s2_spec_val_q;
  logic [3:0]        s2_spec_flg_q;
  logic [EW-1:0]     s2_exp_q;
  logic [PW-1:0]     s2_prod_q, s2_prod_d;

  // stage 3 registers
  logic              s3_valid_q, s3_sign_q, s3_spec_q;
  logic [W-1:0]      s3_spec_val_q;
  logic [3:0]        s3_spec_flg_q;
  logic [EW-1:0]     s3_exp_q, s3_exp_d;
  logic [FRAC_W-1:0] s3_frac_q, s3_frac_d;
  logic              s3_guard_q, s3_guard_d, s3_sticky_q, s3_sticky_d;
  logic [PW-1:0]     norm;

  // output registers
  logic              out_valid_q;
  logic [W-1:0]      dst_q, dst_d;
  logic [3:0]        flags_q, flags_d;
  logic              round_inc, inexact;
  logic [FRAC_W:0]   frac_rnd;
  logic [EW-1:0]     exp_rnd;

  assign in_ready  = !out_valid_q || out_ready;
  assign out_valid = out_valid_q;
  assign dst       = dst_q;
  assign flags     = flags_q;

  assign inf_times_zero = (op_inf[0] && op_zero[1]) || (op_zero[0] && op_inf[1]);

  always_comb begin
    s1_sign_d     = op_sign[0] ^ op_sign[1];
    s1_spec_d     = 1'b0;
    s1_spec_val_d = '0;
    s1_spec_flg_d = '0;
    if (op_nan[0] || op_nan[1] || inf_times_zero) begin
      s1_spec_d     = 1'b1;
      s1_spec_val_d = QNAN;
      s1_spec_flg_d = {inf_times_zero, 3'b000};
    end else if (op_inf[0] || op_inf[1]) begin
      s1_spec_d     = 1'b1;
      s1_spec_val_d = {s1_sign_d, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (op_zero[0] || op_zero[1]) begin
      s1_spec_d     = 1'b1;
      s1_spec_val_d = {s1_sign_d, {(W-1){1'b0}}};
    end
    s1_exp_d = EW'(op_exp[0]) + EW'(op_exp[1]) - EW'(BIAS);
  end

  assign s2_prod_d = PW'(s1_ma_q) * PW'(s1_mb_q);

  // product of two [1,2) significands lies in [1,4); align the leading one to the top
  always_comb begin
    norm        = s2_prod_q[PW-1] ? s2_prod_q : (s2_prod_q << 1);
    s3_exp_d    = s2_exp_q + EW'(s2_prod_q[PW-1]);
    s3_frac_d   = norm[PW-2 -: FRAC_W];
    s3_guard_d  = norm[FRAC_W];
    s3_sticky_d = |norm[FRAC_W-1:0];
  end

  always_comb begin
    round_inc = (ROUND_EN != 0) && s3_guard_q && (s3_sticky_q || s3_frac_q[0]);
    inexact   = s3_guard_q || s3_sticky_q;
    frac_rnd  = {1'b0, s3_frac_q} + {{FRAC_W{1'b0}}, round_inc};
    exp_rnd   = s3_exp_q + {{(EW-1){1'b0}}, frac_rnd[FRAC_W]};
    dst_d     = {s3_sign_q, exp_rnd[EXP_W-1:0], frac_rnd[FRAC_W-1:0]};
    flags_d   = {3'b000, inexact};
    if (s3_spec_q) begin
      dst_d   = s3_spec_val_q;
      flags_d = s3_spec_flg_q;
    end else if ($signed(exp_rnd) >= $signed(EXP_MAX)) begin
      dst_d   = {s3_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      flags_d = 4'b0101;
    end else if (exp_rnd[EW-1] || (exp_rnd == '0)) begin
      dst_d   = {s3_sign_q, {(W-1){1'b0}}};
      flags_d = 4'b0011;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_spec_q     <= 1'b0;
      s1_spec_val_q <= '0;
      s1_spec_flg_q <= '0;
      s1_exp_q      <= '0;
      s1_ma_q       <= '0;
      s1_mb_q       <= '0;
      s2_valid_q    <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_spec_q     <= 1'b0;
      s2_spec_val_q <= '0;
      s2_spec_flg_q <= '0;
      s2_exp_q      <= '0;
      s2_prod_q     <= '0;
      s3_valid_q    <= 1'b0;
      s3_sign_q     <= 1'b0;
      s3_spec_q     <= 1'b0;
      s3_spec_val_q <= '0;
      s3_spec_flg_q <= '0;
      s3_exp_q      <= '0;
      s3_frac_q     <= '0;
      s3_guard_q    <= 1'b0;
      s3_sticky_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      dst_q         <= '0;
      flags_q       <= '0;
    end else if (in_ready) begin
      s1_valid_q    <= in_valid;
      s1_sign_q     <= s1_sign_d;
      s1_spec_q     <= s1_spec_d;
      s1_spec_val_q <= s1_spec_val_d;
      s1_spec_flg_q <= s1_spec_flg_d;
      s1_exp_q      <= s1_exp_d;
      s1_ma_q       <= {1'b1, op_frac[0]};
      s1_mb_q       <= {1'b1, op_frac[1]};
      s2_valid_q    <= s1_valid_q;
      s2_sign_q     <= s1_sign_q;
      s2_spec_q     <= s1_spec_q;
      s2_spec_val_q <= s1_spec_val_q;
      s2_spec_flg_q <= s1_spec_flg_q;
      s2_exp_q      <= s1_exp_q;
      s2_prod_q     <= s2_prod_d;
      s3_valid_q    <= s2_valid_q;
      s3_sign_q     <= s2_sign_q;
      s3_spec_q     <= s2_spec_q;
      s3_spec_val_q <= s2_spec_val_q;
      s3_spec_flg_q <= s2_spec_flg_q;
      s3_exp_q      <= s3_exp_d;
      s3_frac_q     <= s3_frac_d;
      s3_guard_q    <= s3_guard_d;
      s3_sticky_q   <= s3_sticky_d;
      out_valid_q   <= s3_valid_q;
      dst_q         <= dst_d;
      flags_q       <= flags_d;
    end
  end

endmodule
